// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   Two-entry skid buffer between the EX and MEM pipeline stages. The main
//   entry drives the MEM stage. The skid entry catches one instruction that
//   was accepted while MEM stalled. Because of the skid entry, in_ready is a
//   plain flop, so backpressure does not ripple combinationally into EX.
//   The youngest held instruction that writes a nonzero rd is offered back
//   to the ALU operand muxes as a forwarding candidate.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   flush                    squash every held entry and any input this cycle
//   in_valid / in_ready      EX-side handshake (in_ready registered)
//   in_result, in_store_data, in_pc, in_rd, in_mem_read, in_mem_write,
//   in_reg_write, in_funct3  instruction payload from EX
//   out_valid / out_ready    MEM-side handshake
//   out_*                    main-entry payload toward MEM
//   fwd_valid, fwd_rd, fwd_data  forwarding candidate, from registered state only
module ex_mem_skid_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [4:0]        in_rd,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_reg_write,
   input  logic [2:0]        in_funct3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [DATA_W-1:0] out_pc,
   output logic [4:0]        out_rd,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_reg_write,
   output logic [2:0]        out_funct3,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [DATA_W-1:0] fwd_data
);

   // Packed payload layout, LSB first:
   // funct3 | reg_write | mem_write | mem_read | rd | pc | store_data | result
   localparam int F3_LSB  = 0;
   localparam int RW_BIT  = 3;
   localparam int MW_BIT  = 4;
   localparam int MR_BIT  = 5;
   localparam int RD_LSB  = 6;
   localparam int PC_LSB  = 11;
   localparam int SD_LSB  = PC_LSB + DATA_W;
   localparam int RES_LSB = SD_LSB + DATA_W;
   localparam int PAY_W   = RES_LSB + DATA_W;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

   occ_t             state_p1, state_nxt;
   logic             in_ready_p1;
   logic [PAY_W-1:0] main_p1, skid_p1, in_pay;
   logic             vld_main, vld_skid;
   logic             in_fire, out_fire;
   logic             ld_main_in, ld_main_skid, ld_skid_in;
   logic             main_fwd, skid_fwd;

   assign in_pay = {in_result, in_store_data, in_pc, in_rd,
                    in_mem_read, in_mem_write, in_reg_write, in_funct3};

   assign in_fire  = in_valid & in_ready_p1;
   assign out_fire = vld_main & out_ready;

   // State and payload registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p1    <= EMPTY;
         in_ready_p1 <= 1'b1;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else begin
         state_p1    <= state_nxt;
         in_ready_p1 <= (state_nxt != TWO);
         if (ld_main_in)
            main_p1 <= in_pay;
         else if (ld_main_skid)
            main_p1 <= skid_p1;
         if (ld_skid_in)
            skid_p1 <= in_pay;
      end
   end

   // Next occupancy
   always_comb begin
      state_nxt = state_p1;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state_p1)
            EMPTY:   if (in_fire) state_nxt = ONE;
            ONE: begin
               if (in_fire && !out_fire)
                  state_nxt = TWO;
               else if (!in_fire && out_fire)
                  state_nxt = EMPTY;
            end
            TWO:     if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Valid decode and payload load enables. A flush only clears occupancy,
   // so no payload moves in a flush cycle.
   always_comb begin
      vld_main     = (state_p1 == ONE) || (state_p1 == TWO);
      vld_skid     = (state_p1 == TWO);
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
      if (!flush) begin
         case (state_p1)
            EMPTY: ld_main_in = in_fire;
            ONE: begin
               ld_main_in = in_fire & out_fire;
               ld_skid_in = in_fire & ~out_fire;
            end
            TWO:   ld_main_skid = out_fire;
            default: ;
         endcase
      end
   end

   assign in_ready       = in_ready_p1;
   assign out_valid      = vld_main;
   assign out_result     = main_p1[RES_LSB +: DATA_W];
   assign out_store_data = main_p1[SD_LSB +: DATA_W];
   assign out_pc         = main_p1[PC_LSB +: DATA_W];
   assign out_rd         = main_p1[RD_LSB +: 5];
   assign out_mem_read   = main_p1[MR_BIT];
   assign out_mem_write  = main_p1[MW_BIT];
   assign out_reg_write  = main_p1[RW_BIT];
   assign out_funct3     = main_p1[F3_LSB +: 3];

   // The skid entry is younger than the main entry, so when it qualifies its
   // value is the newest one for that register.
   assign skid_fwd  = vld_skid & skid_p1[RW_BIT] & (skid_p1[RD_LSB +: 5] != 5'd0);
   assign main_fwd  = vld_main & main_p1[RW_BIT] & (main_p1[RD_LSB +: 5] != 5'd0);
   assign fwd_valid = skid_fwd | main_fwd;
   assign fwd_rd    = skid_fwd ? skid_p1[RD_LSB +: 5] : main_p1[RD_LSB +: 5];
   assign fwd_data  = skid_fwd ? skid_p1[RES_LSB +: DATA_W] : main_p1[RES_LSB +: DATA_W];

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg
//   Directed scenarios for the EX/MEM skid buffer plus a randomized
//   handshake run against a queue model of the expected FIFO contents.
module tb_ex_mem_skid_reg;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [31:0] in_result, in_store_data, in_pc;
   logic [4:0]  in_rd;
   logic        in_mem_read, in_mem_write, in_reg_write;
   logic [2:0]  in_funct3;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_store_data, out_pc;
   logic [4:0]  out_rd;
   logic        out_mem_read, out_mem_write, out_reg_write;
   logic [2:0]  out_funct3;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] r;
      logic [4:0]  rd;
      logic        rw;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   ex_mem_skid_reg #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_store_data(in_store_data), .in_pc(in_pc),
      .in_rd(in_rd), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_reg_write(in_reg_write), .in_funct3(in_funct3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data), .out_pc(out_pc),
      .out_rd(out_rd), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_reg_write(out_reg_write), .out_funct3(out_funct3),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   // Advance one clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction; the secondary fields are derived from the result
   // so a full-payload comparison can be rebuilt from (result, rd, reg_write).
   task automatic drive(input logic [31:0] r, input logic [4:0] rd, input logic rw);
      in_result     = r;
      in_store_data = ~r;
      in_pc         = 32'h1000 + {r[29:0], 2'b00};
      in_rd         = rd;
      in_reg_write  = rw;
      in_funct3     = r[2:0];
      in_mem_read   = r[3];
      in_mem_write  = r[4];
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(32'h55, 5'd3, 1'b1); in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%0b exp=1", out_valid); end
      reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid got=%0b exp=0", fwd_valid); end
      checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rst_out_result got=%0h exp=0", out_result); end
      checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rst_out_rd got=%0d exp=0", out_rd); end
      checks++;
      if ({out_reg_write, out_mem_read, out_mem_write, out_funct3, out_pc, out_store_data} !== 70'h0) begin
         errors++; $display("FAIL rst_ctrl_payload got=%0h exp=0",
                            {out_reg_write, out_mem_read, out_mem_write, out_funct3, out_pc, out_store_data});
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive(32'h10, 5'd5, 1'b1); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%0b exp=1", out_valid); end
      checks++; if (out_result !== 32'h10) begin errors++; $display("FAIL basic_out_result got=%0h exp=10", out_result); end
      checks++; if (out_pc !== 32'h1040) begin errors++; $display("FAIL basic_out_pc got=%0h exp=1040", out_pc); end
      checks++; if (out_store_data !== 32'hFFFF_FFEF) begin errors++; $display("FAIL basic_store got=%0h exp=ffffffef", out_store_data); end
      checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL basic_fwd_valid got=%0b exp=1", fwd_valid); end
      checks++; if (fwd_rd !== 5'd5) begin errors++; $display("FAIL basic_fwd_rd got=%0d exp=5", fwd_rd); end
      checks++; if (fwd_data !== 32'h10) begin errors++; $display("FAIL basic_fwd_data got=%0h exp=10", fwd_data); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%0b exp=0", out_valid); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL basic_fwd_drained got=%0b exp=0", fwd_valid); end
   endtask

   task automatic test_stall_order();
      out_ready = 1'b0;
      drive(32'hA, 5'd1, 1'b1); in_valid = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_one got=%0b exp=1", in_ready); end
      drive(32'hB, 5'd2, 1'b1);
      step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_two got=%0b exp=0", in_ready); end
      checks++; if (out_result !== 32'hA) begin errors++; $display("FAIL stall_head got=%0h exp=a", out_result); end
      checks++; if (fwd_data !== 32'hB || fwd_rd !== 5'd2) begin errors++; $display("FAIL stall_fwd got=%0h/%0d exp=b/2", fwd_data, fwd_rd); end
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hA) begin errors++; $display("FAIL stall_hold got=%0b/%0h exp=1/a", out_valid, out_result); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hB) begin errors++; $display("FAIL stall_second got=%0b/%0h exp=1/b", out_valid, out_result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got=%0b exp=1", in_ready); end
      checks++; if (fwd_data !== 32'hB) begin errors++; $display("FAIL stall_fwd_after got=%0h exp=b", fwd_data); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%0b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, in_ready); end
         drive(i, 5'(i), 1'b1); in_valid = 1'b1;
         step();
         checks++;
         if (out_valid !== 1'b1 || out_result !== 32'(i)) begin
            errors++; $display("FAIL b2b_out[%0d] got=%0b/%0h exp=1/%0h", i, out_valid, out_result, i);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      // Flush while full: the offered 0xFF must never show up.
      out_ready = 1'b0;
      drive(32'h21, 5'd4, 1'b1); in_valid = 1'b1; step();
      drive(32'h22, 5'd6, 1'b1); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two got=%0b exp=0", in_ready); end
      flush = 1'b1; drive(32'hFF, 5'd7, 1'b1);
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush2_in_ready got=%0b exp=1", in_ready); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL flush2_fwd_valid got=%0b exp=0", fwd_valid); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_no_ff got=%0b/%0h exp=0", out_valid, out_result); end
      // Flush with one held and a acceptable input: the input is dropped too.
      out_ready = 1'b0;
      drive(32'h31, 5'd8, 1'b1); in_valid = 1'b1; step();
      flush = 1'b1; drive(32'hEE, 5'd9, 1'b1);
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush1_state got=%0b/%0b exp=0/1", out_valid, in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_no_ee got=%0b/%0h exp=0", out_valid, out_result); end
   endtask

   task automatic test_rd_zero();
      out_ready = 1'b0;
      drive(32'h33, 5'd0, 1'b1); in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd0_out_valid got=%0b exp=1", out_valid); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rd0_fwd_main got=%0b exp=0", fwd_valid); end
      drive(32'h44, 5'd7, 1'b0);
      step();
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rd0_fwd_norw got=%0b exp=0", fwd_valid); end
      flush = 1'b1; in_valid = 1'b0; step(); flush = 1'b0;
      // Skid with rd=0 must fall back to the qualifying main entry.
      drive(32'h55, 5'd9, 1'b1); in_valid = 1'b1; step();
      drive(32'h66, 5'd0, 1'b1); step();
      in_valid = 1'b0;
      checks++;
      if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== 32'h55) begin
         errors++; $display("FAIL rd0_fwd_fallback got=%0b/%0d/%0h exp=1/9/55", fwd_valid, fwd_rd, fwd_data);
      end
      flush = 1'b1; step(); flush = 1'b0;
   endtask

   task automatic test_reset_in_two();
      out_ready = 1'b0;
      drive(32'h71, 5'd1, 1'b1); in_valid = 1'b1; step();
      drive(32'h72, 5'd2, 1'b1); step();
      reset = 1'b1; flush = 1'b1; out_ready = 1'b1; drive(32'h77, 5'd3, 1'b1);
      step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst2_state got=%0b/%0b exp=0/1", out_valid, in_ready); end
      checks++; if (out_result !== 32'h0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL rst2_clear got=%0h/%0b exp=0/0", out_result, fwd_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst2_no_77 got=%0b/%0h exp=0", out_valid, out_result); end
   endtask

   task automatic test_random();
      ent_t        e, new_e;
      logic        in_f, out_f, exp_fv, prev_stall;
      logic [4:0]  exp_frd;
      logic [31:0] exp_fd;
      logic [108:0] prev_out;
      int          rand_errs;
      rand_errs  = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         checks++;
         if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
            errors++; rand_errs++;
            if (rand_errs < 20) $display("FAIL rnd_occupancy cyc=%0d got=%0b/%0b exp=%0b/%0b",
                                         c, in_ready, out_valid, q.size() < 2, q.size() > 0);
         end
         if (q.size() > 0) begin
            e = q[0];
            checks++;
            if ({out_result, out_store_data, out_pc, out_rd, out_reg_write, out_funct3, out_mem_read, out_mem_write}
                !== {e.r, ~e.r, 32'h1000 + {e.r[29:0], 2'b00}, e.rd, e.rw, e.r[2:0], e.r[3], e.r[4]}) begin
               errors++; rand_errs++;
               if (rand_errs < 20) $display("FAIL rnd_payload cyc=%0d got=%0h/%0d exp=%0h/%0d", c, out_result, out_rd, e.r, e.rd);
            end
         end
         if (prev_stall) begin
            checks++;
            if ({out_result, out_store_data, out_pc, out_rd, out_reg_write, out_funct3, out_mem_read, out_mem_write} !== prev_out) begin
               errors++; rand_errs++;
               if (rand_errs < 20) $display("FAIL rnd_stable cyc=%0d got=%0h exp=%0h", c, out_result, prev_out[108:77]);
            end
         end
         exp_fv = 1'b0; exp_frd = 5'd0; exp_fd = 32'h0;
         if (q.size() == 2 && q[1].rw && q[1].rd != 5'd0) begin
            exp_fv = 1'b1; exp_frd = q[1].rd; exp_fd = q[1].r;
         end else if (q.size() > 0 && q[0].rw && q[0].rd != 5'd0) begin
            exp_fv = 1'b1; exp_frd = q[0].rd; exp_fd = q[0].r;
         end
         checks++;
         if (fwd_valid !== exp_fv || (exp_fv && (fwd_rd !== exp_frd || fwd_data !== exp_fd))) begin
            errors++; rand_errs++;
            if (rand_errs < 20) $display("FAIL rnd_fwd cyc=%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h",
                                         c, fwd_valid, fwd_rd, fwd_data, exp_fv, exp_frd, exp_fd);
         end
         in_valid  = ($urandom_range(0, 9) < 6);
         out_ready = ($urandom_range(0, 9) < 6);
         drive($urandom(), 5'($urandom_range(0, 31) & ($urandom_range(0, 3) == 0 ? 0 : 31)), 1'($urandom_range(0, 1)));
         in_f  = in_valid && (q.size() < 2);
         out_f = out_ready && (q.size() > 0);
         new_e = '{r: in_result, rd: in_rd, rw: in_reg_write};
         prev_stall = (q.size() > 0) && !out_ready;
         prev_out   = {out_result, out_store_data, out_pc, out_rd, out_reg_write, out_funct3, out_mem_read, out_mem_write};
         step();
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back(new_e);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_drain got=%0b exp=0", out_valid); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(32'h0, 5'd0, 1'b0);
      step(); step();
      reset = 1'b0;
      test_reset();
      test_basic();
      test_stall_order();
      test_back_to_back();
      test_flush();
      test_rd_zero();
      test_reset_in_two();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
